// File: rtl/piso_tx.sv
// piso_tx: framed parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it LSB first,
// framed by one start bit (0) and one stop bit (1). Each bit is held on the
// line for BIT_CYCLES clocks.
//
// Ports:
//   clk        - clock, rising edge active
//   rst_n      - asynchronous active-low reset
//   din        - word to send, sampled only when a load is accepted
//   load_valid - caller requests a frame
//   load_ready - high only in IDLE; load taken on load_valid && load_ready
//   sout       - serial line, idles high
//   sout_b     - registered complement of sout
//   busy       - high for the whole frame (start, data, stop)
//   done       - one-cycle pulse in the first IDLE cycle after the stop bit
module piso_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_b,
  output logic             busy,
  output logic             done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_nx;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    idx_q;
  logic             sout_q, sout_b_q, busy_q, done_q, ready_q;
  logic             bit_end;

  assign sh_nx   = sh_q >> 1;
  assign bit_end = (cnt_q == CW'(BIT_CYCLES - 1));

  // Every output is computed as next-state and registered, so the line value
  // for a state is already on sout in the first cycle of that state. sout and
  // sout_b are separate flops loaded with complementary values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      sout_q   <= 1'b1;
      sout_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            sh_q     <= din;
            cnt_q    <= '0;
            state_q  <= START;
            sout_q   <= 1'b0;
            sout_b_q <= 1'b1;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= DATA;
            sout_q   <= sh_q[0];
            sout_b_q <= ~sh_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            sh_q  <= sh_nx;
            if (idx_q == IW'(WIDTH - 1)) begin
              state_q  <= STOP;
              sout_q   <= 1'b1;
              sout_b_q <= 1'b0;
            end else begin
              idx_q    <= idx_q + IW'(1);
              sout_q   <= sh_nx[0];
              sout_b_q <= ~sh_nx[0];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = ready_q;
  assign sout       = sout_q;
  assign sout_b     = sout_b_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one instance at WIDTH=8/BIT_CYCLES=4 and one
// at WIDTH=4/BIT_CYCLES=1, sharing clock and reset.
module tb_piso_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       lv;
  logic       rdy, so, sob, bsy, dn;
  logic [3:0] din2;
  logic       lv2;
  logic       rdy2, so2, sob2, bsy2, dn2;

  int nvec;
  int nerr;

  piso_tx #(.WIDTH(8), .BIT_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(lv),
    .load_ready(rdy), .sout(so), .sout_b(sob), .busy(bsy), .done(dn)
  );

  piso_tx #(.WIDTH(4), .BIT_CYCLES(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .load_valid(lv2),
    .load_ready(rdy2), .sout(so2), .sout_b(sob2), .busy(bsy2), .done(dn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    check({tag, ".sout"}, {31'd0, so}, 32'd1);
    check({tag, ".sout_b"}, {31'd0, sob}, 32'd0);
    check({tag, ".busy"}, {31'd0, bsy}, 32'd0);
    check({tag, ".done"}, {31'd0, dn}, 32'd0);
    check({tag, ".ready"}, {31'd0, rdy}, 32'd1);
  endtask

  // Sends d on the 8/4 instance and checks every frame cycle through the done
  // cycle. mode 0: load_valid low during frame; 1: pulse with din_mid mid-frame;
  // 2: load_valid held high with din_mid (next load accepted in done cycle).
  // Returns with the bench sitting in the done cycle.
  task automatic frame(input string tag, input logic [7:0] d, input logic [7:0] din_mid,
                       input int mode);
    logic exp;
    int   b;
    din = d;
    lv  = 1'b1;
    tick();
    din = din_mid;
    for (int c = 1; c <= 40; c++) begin
      lv = (mode == 2) || (mode == 1 && c >= 10 && c < 13);
      b  = (c - 1) / 4;
      if (b == 0)      exp = 1'b0;
      else if (b == 9) exp = 1'b1;
      else             exp = d[b-1];
      check($sformatf("%s.c%0d.sout", tag, c), {31'd0, so}, {31'd0, exp});
      check($sformatf("%s.c%0d.sout_b", tag, c), {31'd0, sob}, {31'd0, ~exp});
      check($sformatf("%s.c%0d.busy", tag, c), {31'd0, bsy}, 32'd1);
      check($sformatf("%s.c%0d.done", tag, c), {31'd0, dn}, 32'd0);
      check($sformatf("%s.c%0d.ready", tag, c), {31'd0, rdy}, 32'd0);
      tick();
    end
    if (mode != 2) lv = 1'b0;
    check({tag, ".done_pulse"}, {31'd0, dn}, 32'd1);
    check({tag, ".done_ready"}, {31'd0, rdy}, 32'd1);
    check({tag, ".done_busy"}, {31'd0, bsy}, 32'd0);
    check({tag, ".done_sout"}, {31'd0, so}, 32'd1);
    check({tag, ".done_soutb"}, {31'd0, sob}, 32'd0);
  endtask

  logic [5:0] seq2;

  initial begin
    nvec  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    din   = '0;
    lv    = 1'b0;
    din2  = '0;
    lv2   = 1'b0;

    // Reset with random inputs; outputs must stay at idle values.
    for (int i = 0; i < 5; i++) begin
      din  = 8'($urandom);
      lv   = 1'($urandom);
      din2 = 4'($urandom);
      lv2  = 1'($urandom);
      tick();
      idle_chk($sformatf("rst%0d", i));
      check("rst.b.sout", {31'd0, so2}, 32'd1);
      check("rst.b.sout_b", {31'd0, sob2}, 32'd0);
      check("rst.b.ready", {31'd0, rdy2}, 32'd1);
    end
    lv    = 1'b0;
    lv2   = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      idle_chk($sformatf("idle%0d", i));
      check("idle.b.busy", {31'd0, bsy2}, 32'd0);
    end

    // Single frame 0xA5, then back to idle.
    frame("a5", 8'hA5, 8'h00, 0);
    tick();
    idle_chk("a5.after");

    // Back-to-back 0x00 then 0xFF with load_valid held: second accepted in the
    // first frame's done cycle, so the done cycle is the only idle-high gap.
    frame("b2b0", 8'h00, 8'hFF, 2);
    frame("b2b1", 8'hFF, 8'hFF, 0);
    tick();
    idle_chk("b2b.after");

    // Load pulse with 0x3C mid-frame is ignored; no extra frame follows.
    frame("ign", 8'h81, 8'h3C, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      idle_chk($sformatf("ign.after%0d", i));
    end

    // Reset during data bit 3 (cycles 17..20 after accept).
    din = 8'hA5;
    lv  = 1'b1;
    tick();
    lv = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("mid.bit3", {31'd0, so}, 32'd0);
    check("mid.busy_pre", {31'd0, bsy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid.sout_async", {31'd0, so}, 32'd1);
    check("mid.soutb_async", {31'd0, sob}, 32'd0);
    check("mid.busy_async", {31'd0, bsy}, 32'd0);
    check("mid.ready_async", {31'd0, rdy}, 32'd1);
    tick();
    idle_chk("mid.inrst");
    rst_n = 1'b1;
    frame("post", 8'h5A, 8'h00, 0);
    tick();
    idle_chk("post.after");

    // WIDTH=4, BIT_CYCLES=1, load 0x6: line 0,0,1,1,0,1 then done.
    seq2 = 6'b101100;
    din2 = 4'h6;
    lv2  = 1'b1;
    tick();
    lv2 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("bc1.c%0d.sout", c), {31'd0, so2}, {31'd0, seq2[c]});
      check($sformatf("bc1.c%0d.sout_b", c), {31'd0, sob2}, {31'd0, ~seq2[c]});
      check($sformatf("bc1.c%0d.busy", c), {31'd0, bsy2}, 32'd1);
      check($sformatf("bc1.c%0d.done", c), {31'd0, dn2}, 32'd0);
      tick();
    end
    check("bc1.done", {31'd0, dn2}, 32'd1);
    check("bc1.busy_end", {31'd0, bsy2}, 32'd0);
    check("bc1.ready_end", {31'd0, rdy2}, 32'd1);
    tick();
    check("bc1.done_clr", {31'd0, dn2}, 32'd0);
    check("bc1.sout_idle", {31'd0, so2}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
